pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory/fetch stalls, load-use interlock and redirect flush.
// Event counters are built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int PIPE_REGS    = 4,
    parameter int REGW         = 3,
    parameter int MEM_IDX      = 2,
    parameter int REDIRECT_IDX = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 redirect,
    input  logic [REGW-1:0]      id_sr1,
    input  logic [REGW-1:0]      id_sr2,
    input  logic                 id_use_sr1,
    input  logic                 id_use_sr2,
    input  logic [REGW-1:0]      id_dest,
    input  logic                 id_wr,
    input  logic                 id_ld,
    output logic [PIPE_REGS-1:0] pipe_load,
    output logic [PIPE_REGS-1:0] pipe_valid,
    output logic                 pc_load,
    output logic                 interlock,
    output logic                 flush,
    output logic [15:0]          perf_stall,
    output logic [15:0]          perf_bubble,
    output logic [15:0]          perf_flush
);

    logic                 stall;
    logic                 src_hit;
    logic [PIPE_REGS-1:0] valid_nxt;
    logic [REGW-1:0]      dest_q [1:PIPE_REGS-1];
    logic [PIPE_REGS-1:1] wr_q;
    logic [PIPE_REGS-1:1] ld_q;
    logic                 unused_meta;

    // Oldest metadata slot is carried for completeness but nothing downstream reads it.
    assign unused_meta = ^{dest_q[PIPE_REGS-1], wr_q[PIPE_REGS-1], ld_q[PIPE_REGS-1]};

    always_comb begin
        stall     = !imem_resp || (pipe_valid[MEM_IDX] && dmem_req && !dmem_resp);
        src_hit   = (id_use_sr1 && (id_sr1 == dest_q[1])) ||
                    (id_use_sr2 && (id_sr2 == dest_q[1]));
        flush     = !stall && redirect && pipe_valid[REDIRECT_IDX];
        interlock = !stall && !redirect && pipe_valid[0] && pipe_valid[1] &&
                    ld_q[1] && wr_q[1] && src_hit;
        pipe_load = '1;
        pc_load   = 1'b1;
        valid_nxt = {pipe_valid[PIPE_REGS-2:0], 1'b1};
        if (stall) begin
            pipe_load = '0;
            pc_load   = 1'b0;
            valid_nxt = pipe_valid;
        end else if (flush) begin
            for (int k = 0; k <= REDIRECT_IDX; k++) begin
                valid_nxt[k] = 1'b0;
            end
        end else if (interlock) begin
            // Decode instruction waits in reg 0 while a bubble enters reg 1.
            pc_load      = 1'b0;
            pipe_load[0] = 1'b0;
            valid_nxt[0] = pipe_valid[0];
            valid_nxt[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            wr_q       <= '0;
            ld_q       <= '0;
            for (int k = 1; k < PIPE_REGS; k++) begin
                dest_q[k] <= '0;
            end
        end else if (!stall) begin
            pipe_valid <= valid_nxt;
            dest_q[1]  <= id_dest;
            wr_q[1]    <= id_wr && !interlock;
            ld_q[1]    <= id_ld && !interlock;
            for (int k = 2; k < PIPE_REGS; k++) begin
                dest_q[k] <= dest_q[k-1];
                wr_q[k]   <= wr_q[k-1];
                ld_q[k]   <= ld_q[k-1];
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else begin
            if (stall && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
            if (interlock && (perf_bubble != 16'hFFFF)) begin
                perf_bubble <= perf_bubble + 16'd1;
            end
            if (flush && (perf_flush != 16'hFFFF)) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`else
    assign perf_stall  = 16'h0000;
    assign perf_bubble = 16'h0000;
    assign perf_flush  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random traffic against a
// behavioural pipeline model (instruction records shifted through an array).
module tb_pipe_hazard_ctrl;
    localparam int P  = 4;
    localparam int RW = 3;
    localparam int MI = 2;
    localparam int RI = 2;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0, redirect = 1'b0;
    logic [RW-1:0] id_sr1 = '0, id_sr2 = '0, id_dest = '0;
    logic          id_use_sr1 = 1'b0, id_use_sr2 = 1'b0, id_wr = 1'b0, id_ld = 1'b0;
    logic [P-1:0]  pipe_load, pipe_valid;
    logic          pc_load, interlock, flush;
    logic [15:0]   perf_stall, perf_bubble, perf_flush;

    pipe_hazard_ctrl #(.PIPE_REGS(P), .REGW(RW), .MEM_IDX(MI), .REDIRECT_IDX(RI)) dut (
        .clk(clk), .reset_n(reset_n), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .redirect(redirect), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_use_sr1(id_use_sr1), .id_use_sr2(id_use_sr2), .id_dest(id_dest),
        .id_wr(id_wr), .id_ld(id_ld), .pipe_load(pipe_load), .pipe_valid(pipe_valid),
        .pc_load(pc_load), .interlock(interlock), .flush(flush),
        .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
    );

    always #5 clk = ~clk;

    // Model: one record per pipe reg (valid + decoded metadata of the instruction it holds).
    bit            mv [P];
    logic [RW-1:0] md [P];
    bit            mw [P];
    bit            ml [P];
    int            m_ps, m_pb, m_pf;
    int            total = 0;
    int            bad = 0;
    bit            e_stall, e_ilk, e_flush, e_pc;
    logic [P-1:0]  e_load;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] vpack();
        logic [P-1:0] v;
        for (int k = 0; k < P; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic int sat(input int c);
        return (c < 65535) ? c + 1 : 65535;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < P; k++) begin
            mv[k] = 0; md[k] = '0; mw[k] = 0; ml[k] = 0;
        end
        m_ps = 0; m_pb = 0; m_pf = 0;
    endtask

    task automatic model_comb();
        bit hit;
        hit     = (id_use_sr1 && id_sr1 == md[1]) || (id_use_sr2 && id_sr2 == md[1]);
        e_stall = !imem_resp || (mv[MI] && dmem_req && !dmem_resp);
        e_flush = !e_stall && redirect && mv[RI];
        e_ilk   = !e_stall && !redirect && mv[0] && mv[1] && ml[1] && mw[1] && hit;
        e_pc    = !e_stall && !e_ilk;
        e_load  = e_stall ? '0 : (e_ilk ? {{(P-1){1'b1}}, 1'b0} : '1);
    endtask

    task automatic model_edge();
        bit            nv [P];
        logic [RW-1:0] nd [P];
        bit            nw [P];
        bit            nl [P];
        if (e_stall) begin
            m_ps = sat(m_ps);
            return;
        end
        if (e_ilk) m_pb = sat(m_pb);
        if (e_flush) m_pf = sat(m_pf);
        nv[0] = 1; nd[0] = '0; nw[0] = 0; nl[0] = 0;
        nd[1] = id_dest; nw[1] = id_wr; nl[1] = id_ld;
        for (int k = 1; k < P; k++) nv[k] = mv[k-1];
        for (int k = 2; k < P; k++) begin
            nd[k] = md[k-1]; nw[k] = mw[k-1]; nl[k] = ml[k-1];
        end
        if (e_flush) begin
            for (int k = 0; k <= RI; k++) nv[k] = 0;
        end else if (e_ilk) begin
            nv[0] = mv[0]; nv[1] = 0; nw[1] = 0; nl[1] = 0;
        end
        mv = nv; md = nd; mw = nw; ml = nl;
    endtask

    task automatic step(input bit im, input bit dq, input bit dr, input bit rd,
                        input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                        input bit u1, input bit u2, input logic [RW-1:0] dst,
                        input bit w, input bit l,
                        output logic o_ilk, output logic o_flush, output logic o_pc,
                        output logic [P-1:0] o_load);
        @(negedge clk);
        imem_resp = im; dmem_req = dq; dmem_resp = dr; redirect = rd;
        id_sr1 = s1; id_sr2 = s2; id_use_sr1 = u1; id_use_sr2 = u2;
        id_dest = dst; id_wr = w; id_ld = l;
        #1;
        model_comb();
        check("pipe_valid", pipe_valid, vpack());
        check("pipe_load", pipe_load, e_load);
        check("pc_load", pc_load, e_pc);
        check("interlock", interlock, e_ilk);
        check("flush", flush, e_flush);
        check("perf_stall", perf_stall, PERF_ON ? m_ps : 0);
        check("perf_bubble", perf_bubble, PERF_ON ? m_pb : 0);
        check("perf_flush", perf_flush, PERF_ON ? m_pf : 0);
        o_ilk = interlock; o_flush = flush; o_pc = pc_load; o_load = pipe_load;
        @(posedge clk);
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1 model_clear();
        check("rst_valid", pipe_valid, 0);
        check("rst_interlock", interlock, 0);
        check("rst_flush", flush, 0);
        check("rst_perf", {perf_stall, perf_bubble}, 0);
        check("rst_perf_flush", perf_flush, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic         oi, of, op;
        logic [P-1:0] ol;
        logic [P-1:0] fill [4];
        int           pb_before;
        fill[0] = 4'b0001; fill[1] = 4'b0011; fill[2] = 4'b0111; fill[3] = 4'b1111;
        model_clear();
        do_reset();

        // Fill from reset
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
            check("fill_pc", op, 1);
            #1 check("fill_valid", pipe_valid, fill[i]);
        end

        // Load-use: LDR R2 into reg 1, then consumer reading R2
        step(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, oi, of, op, ol);
        step(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, oi, of, op, ol);
        check("lu_interlock", oi, 1);
        check("lu_pc", op, 0);
        #1 check("lu_bubble_valid", pipe_valid, 4'b1101);
        check("lu_perf_bubble", perf_bubble, PERF_ON ? 1 : 0);
        step(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, oi, of, op, ol);
        check("lu_once", oi, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        #1 check("lu_refill", pipe_valid, 4'b0111);

        // Data-memory stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
            check("dm_load", ol, 0);
            #1 check("dm_hold", pipe_valid, 4'b0111);
        end
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        check("dm_release", ol, 4'hF);
        #1 check("dm_full", pipe_valid, 4'b1111);

        // Redirect flush
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        check("fl_flush", of, 1);
        check("fl_load", ol, 4'hF);
        #1 check("fl_valid", pipe_valid, 4'b1000);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        #1 check("fl_restart", pipe_valid, 4'b0001);

        // Redirect with a simultaneous load-use hazard
        step(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, oi, of, op, ol);
        step(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, oi, of, op, ol);
        pb_before = m_pb;
        step(1, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, oi, of, op, ol);
        check("prio_flush", of, 1);
        check("prio_ilk", oi, 0);
        check("prio_bubble_cnt", perf_bubble, PERF_ON ? pb_before : 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        check("stall_redirect", of, 0);

        // Reset in the middle of a stall
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        #1 check("post_rst_valid", pipe_valid, 4'b0001);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 2) == 1,
                 ($urandom % 8) == 0, RW'($urandom), RW'($urandom),
                 ($urandom % 2) == 1, ($urandom % 2) == 1, RW'($urandom % 4),
                 ($urandom % 2) == 1, ($urandom % 2) == 1, oi, of, op, ol);
        end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        // Stall counter saturation
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        repeat (70000) begin
            @(posedge clk);
            m_ps = sat(m_ps);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        check("sat_stall", perf_stall, 16'hFFFF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        check("sat_hold", perf_stall, 16'hFFFF);
`else
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, oi, of, op, ol);
        check("perf_off", {perf_stall, perf_bubble}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
